// File: rtl/npu_rd_pkg.sv
// Shared types and constants for the NPU result readback path.
package npu_rd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } rd_state_t;

  localparam logic ADDR_STATUS = 1'b0;
  localparam logic ADDR_DATA   = 1'b1;

  localparam int ST_ARMED   = 12;
  localparam int ST_DONE    = 13;
  localparam int ST_OVF     = 14;
  localparam int ST_UDF     = 15;
  localparam int ST_OVF_CNT = 16;

endpackage

// File: rtl/npu_result_reader_fifo.sv
// Single-clock DEPTHx32 word FIFO with a fall-through head; a push into a
// full FIFO succeeds when a pop frees the slot in the same cycle.
module result_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      wdata,
  output logic [31:0]      head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push & ~clr) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/npu_result_reader.sv
// NPU result readback: packs D_OUT bytes little-endian into words, buffers
// them and serves STATUS/DATA to the host. NPU_RESULT_READER_OVF_CNT_EN adds
// a dropped-word counter in STATUS[31:16].
module npu_result_reader
  import npu_rd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  npu_dout,
  input  logic        npu_valid,
  input  logic        npu_done,
  input  logic        start,
  input  logic        chipselect,
  input  logic        read,
  input  logic        address,
  output logic [31:0] readdata,
  output logic        irq
);

  rd_state_t        state, state_nxt;
  logic [23:0]      pack;
  logic [1:0]       idx, idx_nxt;
  logic             ovf, udf;
  logic             capturing, accept, last_byte, flush, push;
  logic             host_rd, data_rd, pop, drop;
  logic [31:0]      word, head, status;
  logic             full, empty;
  logic [CNT_W-1:0] count;

  // start overrides everything else on the same cycle
  assign capturing = (state == CAPTURE) & ~start;
  assign accept    = capturing & npu_valid;
  assign idx_nxt   = accept ? idx + 2'd1 : idx;
  assign last_byte = accept & (idx == 2'd3);
  assign flush     = capturing & npu_done & (idx_nxt != 2'd0);
  assign push      = last_byte | flush;

  assign host_rd = chipselect & read;
  assign data_rd = host_rd & (address == ADDR_DATA) & ~start;
  assign pop     = data_rd & ~empty;
  assign drop    = push & full & ~pop;
  assign irq     = (state == DONE) & ~empty;

  // Lanes above idx are always zero, so a flush needs no extra masking.
  always_comb begin
    word = {8'h00, pack};
    if (accept) word[8*idx +: 8] = npu_dout;
  end

  always_comb begin
    state_nxt = state;
    if (start)                              state_nxt = CAPTURE;
    else if (state == CAPTURE && npu_done)  state_nxt = DONE;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pack <= '0;
      idx  <= '0;
    end else if (start | push) begin
      pack <= '0;
      idx  <= '0;
    end else if (accept) begin
      pack <= word[23:0];
      idx  <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (start) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (drop)            ovf <= 1'b1;
      if (data_rd & empty) udf <= 1'b1;
    end
  end

`ifdef NPU_RESULT_READER_OVF_CNT_EN
  logic [15:0] ovf_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       ovf_cnt <= '0;
    else if (start)                   ovf_cnt <= '0;
    else if (drop && ovf_cnt != '1)   ovf_cnt <= ovf_cnt + 16'd1;
  end
`endif

  always_comb begin
    status                 = '0;
    status[CNT_W-1:0]      = count;
    status[ST_ARMED]       = (state == CAPTURE);
    status[ST_DONE]        = (state == DONE);
    status[ST_OVF]         = ovf;
    status[ST_UDF]         = udf;
`ifdef NPU_RESULT_READER_OVF_CNT_EN
    status[ST_OVF_CNT +: 16] = ovf_cnt;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              readdata <= '0;
    else if (host_rd) begin
      if (start)                         readdata <= '0;
      else if (address == ADDR_STATUS)   readdata <= status;
      else                               readdata <= empty ? 32'h0 : head;
    end
  end

  result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clr   (start),
    .push  (push),
    .pop   (pop),
    .wdata (word),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_npu_result_reader.sv
// Randomized + directed bench for npu_result_reader against a queue-based model.
module tb_npu_result_reader;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  npu_dout = '0;
  logic        npu_valid = 1'b0, npu_done = 1'b0, start = 1'b0;
  logic        chipselect = 1'b0, read = 1'b0, address = 1'b0;
  logic [31:0] readdata;
  logic        irq;

  npu_result_reader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .npu_dout(npu_dout), .npu_valid(npu_valid),
    .npu_done(npu_done), .start(start), .chipselect(chipselect), .read(read),
    .address(address), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Model: mode 0=idle 1=capture 2=done; pending bytes and stored words as queues.
  int          m_mode = 0;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_fifo[$];
  bit          m_ovf = 0, m_udf = 0;
  int          m_drops = 0;
  logic [31:0] m_rd = '0;
  logic [31:0] m_pre, m_w;
  bit          m_have;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(m_fifo.size());
    if (m_mode == 1) s = s | 32'h1000;
    if (m_mode == 2) s = s | 32'h2000;
    if (m_ovf)       s = s | 32'h4000;
    if (m_udf)       s = s | 32'h8000;
`ifdef NPU_RESULT_READER_OVF_CNT_EN
    s = s | (32'((m_drops > 65535) ? 65535 : m_drops) << 16);
`endif
    return s;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_bytes.delete(); m_fifo.delete();
      m_ovf = 0; m_udf = 0; m_drops = 0; m_rd = '0;
    end else begin
      m_pre = m_status();
      if (start) begin
        m_bytes.delete(); m_fifo.delete();
        m_ovf = 0; m_udf = 0; m_drops = 0; m_mode = 1;
        if (chipselect && read) m_rd = '0;
      end else begin
        m_have = 0; m_w = '0;
        if (m_mode == 1 && npu_valid) begin
          m_bytes.push_back(npu_dout);
          if (m_bytes.size() == 4) m_have = 1;
        end
        if (m_mode == 1 && npu_done) begin
          if (m_bytes.size() > 0) m_have = 1;
          m_mode = 2;
        end
        if (m_have) begin
          for (int k = 0; k < m_bytes.size(); k++) m_w[8*k +: 8] = m_bytes[k];
          m_bytes.delete();
        end
        if (chipselect && read) begin
          if (!address)              m_rd = m_pre;
          else if (m_fifo.size() > 0) m_rd = m_fifo.pop_front();
          else begin m_rd = '0; m_udf = 1; end
        end
        if (m_have) begin
          if (m_fifo.size() < DEPTH) m_fifo.push_back(m_w);
          else begin m_ovf = 1; m_drops++; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      total++;
      if (readdata !== m_rd) begin
        bad++;
        $display("FAIL model_readdata t=%0t got=%h exp=%h", $time, readdata, m_rd);
      end
      total++;
      if (irq !== (m_mode == 2 && m_fifo.size() > 0)) begin
        bad++;
        $display("FAIL model_irq t=%0t got=%b exp=%b", $time, irq, (m_mode == 2 && m_fifo.size() > 0));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic dn,
                     input logic st, input logic rd, input logic a);
    npu_valid = v; npu_dout = d; npu_done = dn; start = st;
    chipselect = rd; read = rd; address = a;
    @(posedge clk); #1;
    npu_valid = 0; npu_done = 0; start = 0; chipselect = 0; read = 0;
  endtask

  task automatic rd(input logic a, input logic [31:0] exp, input string name);
    cyc(0, 8'h00, 0, 0, 1, a);
    chk(name, readdata, exp);
  endtask

  task automatic pulse_reset();
    #3 reset = 1'b0;
    #10 reset = 1'b1;
  endtask

  logic [31:0] ovf_status;

  initial begin
`ifdef NPU_RESULT_READER_OVF_CNT_EN
    ovf_status = 32'h0001_6010;
`else
    ovf_status = 32'h0000_6010;
`endif
    #2 reset = 1'b0;
    #20 reset = 1'b1;

    rd(0, 32'h0, "reset_status");
    chk("reset_irq", {31'b0, irq}, 32'h0);

    // 8 bytes -> two full words
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    rd(0, 32'h0000_2002, "eight_status");
    chk("eight_irq_hi", {31'b0, irq}, 32'h1);
    rd(1, 32'h0403_0201, "eight_w0");
    chk("eight_irq_mid", {31'b0, irq}, 32'h1);
    rd(1, 32'h0807_0605, "eight_w1");
    chk("eight_irq_lo", {31'b0, irq}, 32'h0);

    // 5 bytes with done on the last byte -> partial flush
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 8'(8'hA0 + i), 0, 0, 0, 0);
    cyc(1, 8'hA5, 1, 0, 0, 0);
    rd(1, 32'hA4A3_A2A1, "five_w0");
    rd(1, 32'h0000_00A5, "five_w1");
    rd(0, 32'h0000_2000, "five_status");

    // 68 bytes -> 17 words into a 16-deep FIFO
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 68; i++) cyc(1, 8'(i), 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    rd(0, ovf_status, "ovf_status");
    rd(1, 32'h0302_0100, "ovf_first_word");

    // empty DATA read
    cyc(0, 0, 0, 1, 0, 0);
    rd(1, 32'h0, "udf_data");
    rd(0, 32'h0000_9000, "udf_status");

    // reset mid-frame discards earlier bytes
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 8'hE0 + 8'(i), 0, 0, 0, 0);
    pulse_reset();
    rd(0, 32'h0, "rst_mid_status");
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 8'(8'h10 + i), 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    rd(0, 32'h0000_2001, "rst_mid_status2");
    rd(1, 32'h1413_1211, "rst_mid_word");
    rd(0, 32'h0000_2000, "rst_mid_status3");

    // start together with a DATA read
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'h55, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 1);
    chk("start_read_data", readdata, 32'h0);
    rd(0, 32'h0000_1000, "start_read_status");

    // random traffic, model checked every cycle
    cyc(0, 0, 0, 1, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      logic st, v, dn, r, a;
      st = ($urandom_range(0, 249) == 0);
      v  = ($urandom_range(0, 3) != 0);
      dn = ($urandom_range(0, 59) == 0);
      r  = (n < 2000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
      a  = 1'($urandom_range(0, 1));
      if (n == 2500) begin
        pulse_reset();
        st = 1'b1;
      end
      cyc(v, 8'($urandom), dn, st, r, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npu_result_reader.md
# npu_result_reader

Readback path from the NPU to the host. Captures the 8-bit `D_OUT` result stream, packs bytes little-endian into 32-bit words and buffers them in a FIFO. The host drains the FIFO and polls status over the same 32-bit register bus that `memory_write` uses for loading. Sits beside `memory_write`/`memory_read`, fed by `npu_top`, and complements the host-to-RAM load path.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in 32-bit words; power of two, 4..256.
- `CNT_W`, `$clog2(DEPTH)+1`: occupancy counter width (derived; do not override).

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: reset, asynchronous, active-low.
- `npu_dout` in 8: NPU result byte (`D_OUT`).
- `npu_valid` in 1: `npu_dout` holds a valid byte this cycle.
- `npu_done` in 1: single-cycle pulse; last byte of the result frame has been presented.
- `start` in 1: single-cycle pulse decoded from `control_reg`; clears and arms the block.
- `chipselect` in 1: host bus select.
- `read` in 1: host read strobe.
- `address` in 1: 0 = STATUS, 1 = DATA.
- `readdata` out 32: host read data, registered.
- `irq` out 1: level; high while state is DONE and the FIFO is non-empty.

## Operation
- FSM states:
  - IDLE (reset state): bytes ignored.
  - CAPTURE: bytes accepted.
  - DONE: frame complete; bytes ignored.
- FSM transitions:
  - `start` in any state clears the FIFO, the pack register, the byte index and the sticky flags, then goes to CAPTURE.
  - `npu_done` in CAPTURE goes to DONE.
  - `npu_done` in IDLE or DONE is ignored.
- Packing: a 2-bit byte index selects the lane. Byte k of the frame goes to bits [8*(k%4)+7 : 8*(k%4)].
- Word push: on the 4th byte, the word is assembled from the pack register plus the incoming byte and pushed at that same edge. The index then wraps to 0.
- Flush: on `npu_done` with index != 0, the partial word is pushed with the unused upper lanes zero.
- Same-cycle `npu_valid` and `npu_done`: the byte is accepted first, then the flush covers that byte.
- FIFO full on push: the word is dropped and sticky `ovf` is set. The pack register still clears.
- DATA read (`chipselect & read & address==1`):
  - Non-empty FIFO: pops the head word.
  - Empty FIFO: returns 0, no pop, sets sticky `udf`.
- STATUS read, bit layout:
  - [CNT_W-1:0] occupancy
  - [12] armed (state==CAPTURE)
  - [13] done (state==DONE)
  - [14] `ovf`
  - [15] `udf`
  - [31:16] zero, or the overflow count when configured.
- A STATUS read has no side effects.
- Simultaneous push and pop: both happen and occupancy is unchanged. When full, the pop frees the slot and the push succeeds.
- `start` together with a read: `start` has priority, the pop is suppressed, and `readdata` returns 0.
- Reset mid-frame: everything clears asynchronously and the state returns to IDLE. Buffered data is lost.

## Timing
- Reset values: `readdata`=0, `irq`=0, state IDLE, occupancy 0, flags 0, pack register 0.
- Read latency is 1: `readdata` is valid the cycle after the strobe and holds until the next read.
- Back-to-back DATA reads pop once per cycle.
- Occupancy and the flags reflect a push or pop on the cycle after the edge.
- `irq` rises the cycle after entering DONE if the FIFO is non-empty. It falls the cycle after the last pop.
- Sustained throughput: one byte per cycle with no stall. The NPU side has no backpressure.

## Configuration
- Macro: `NPU_RESULT_READER_OVF_CNT_EN`.
- Defined: 16-bit saturating counter of dropped words, cleared by `start`/reset, mapped to STATUS[31:16].
- Undefined: the counter is absent and STATUS[31:16] reads 0. Sticky `ovf` exists in both builds.

## Structure
- Package `npu_rd_pkg`:
  - state enum `rd_state_t` {IDLE, CAPTURE, DONE}
  - address constants `ADDR_STATUS`, `ADDR_DATA`
  - STATUS bit-position constants
- Sub-module `result_fifo`:
  - synchronous, single clock, `DEPTH`x32
  - push/pop/full/empty/count
  - first-word-fall-through head so a pop's data is registered straight into `readdata`
- Top: FSM, packer, host read mux, flags.

## Test plan
- Reset then STATUS read -> `readdata`=0, `irq`=0.
- `start`, 8 bytes 0x01..0x08 in consecutive cycles, `npu_done` -> STATUS occupancy 2, done=1. DATA reads return 0x04030201, then 0x08070605. `irq` drops after the 2nd pop.
- `start`, 5 bytes 0xA1..0xA5, with `npu_done` in the same cycle as the 5th byte -> words 0xA4A3A2A1 and 0x000000A5.
- `DEPTH`=16, `start`, 68 bytes, `npu_done` -> occupancy 16, `ovf`=1, STATUS[31:16]=1 with the macro and 0 without. First pop returns the first word.
- DATA read on an empty FIFO after `start` -> `readdata`=0, `udf`=1, occupancy stays 0.
- `reset` asserted mid-frame after 3 bytes, then released, `start`, 4 bytes 0x11..0x14, `npu_done` -> a single word 0x14131211; the earlier bytes are not present.
